// File: rtl/ws2812_seq_pkg.sv
// Shared types and helpers for the ws2812 frame sequencer.
// Latency: n/a (types, constants and a pure combinational scaling function).
// Backpressure: n/a.
//
// Contents: bus widths, the sequencer FSM state encoding, and the per-channel
// brightness scaling used when WS2812_SEQ_BRIGHTNESS_EN is defined.
package ws2812_seq_pkg;

  localparam int RGB_W     = 24;
  localparam int LED_NUM_W = 8;
  localparam int CH_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    GAP,
    FIN
  } seq_state_t;

  // (c * b) >> 8: full 16-bit product, keep the upper byte.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [CH_W-1:0] b);
    logic [2*CH_W-1:0] prod;
    prod = {{CH_W{1'b0}}, c} * {{CH_W{1'b0}}, b};
    return prod[2*CH_W-1:CH_W];
  endfunction

  // Scale each of the G, R, B channels independently.
  function automatic logic [RGB_W-1:0] scale_rgb(input logic [RGB_W-1:0] grb,
                                                 input logic [CH_W-1:0]  b);
    return {scale_ch(grb[23:16], b), scale_ch(grb[15:8], b), scale_ch(grb[7:0], b)};
  endfunction

endpackage

// File: rtl/ws2812_frame_ram.sv
// Frame storage: one write port, one asynchronous read port with write-first bypass.
// Latency: write lands at the clock edge; read is combinational (0 cycles).
// Backpressure: none; a write is accepted every cycle.
//
// Ports:
//   clk       clock
//   i_we      write enable (already qualified against the frame length)
//   i_waddr   write row
//   i_wdata   write colour {G,R,B}
//   i_raddr   read row
//   o_rdata   read colour; equals i_wdata when writing the row being read
module ws2812_frame_ram
  import ws2812_seq_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [RGB_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [RGB_W-1:0] o_rdata
);

  // Depth is rounded up to a power of two so the index covers it exactly;
  // rows at or above the frame length are never written or read.
  localparam int DEPTH = 1 << IDX_W;

  // Deliberately no reset: frame contents survive a sequencer reset.
  logic [RGB_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle write to the row being read supplies the new value.
  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Streams a stored frame of GRB colours to the ws2812 driver on commit.
// Latency: first write strobe 2 cycles after commit, then one every WRITE_GAP cycles.
// Backpressure: none; commits while busy collapse into a single pending re-run.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   host_we/addr/data     frame write port (out-of-range addresses ignored)
//   commit                request a full-frame transfer
//   brightness            global scale (only with WS2812_SEQ_BRIGHTNESS_EN)
//   busy, done            transfer in progress / one-cycle end-of-frame pulse
//   rgb_data, led_num     colour and index to the driver, held between strobes
//   write                 one-cycle strobe to the driver
// Optional feature macro: WS2812_SEQ_BRIGHTNESS_EN (per-entry brightness scaling).
module ws2812_frame_sequencer
  import ws2812_seq_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int WRITE_GAP = 16,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [RGB_W-1:0]     host_data,
  input  logic                 commit,
  input  logic [CH_W-1:0]      brightness,
  output logic                 busy,
  output logic                 done,
  output logic [RGB_W-1:0]     rgb_data,
  output logic [LED_NUM_W-1:0] led_num,
  output logic                 write
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int GAP_W = $clog2(WRITE_GAP + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   NUM_EXT   = (ADDR_W + 1)'(NUM_LEDS);
  // GAP lasts WRITE_GAP-2 cycles; with STROBE and LOAD that spaces strobes WRITE_GAP apart.
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(WRITE_GAP - 2);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  seq_state_t           r_state;
  seq_state_t           w_state_nxt;
  logic [ADDR_W-1:0]    r_index;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_pending;
  logic [RGB_W-1:0]     r_rgb;
  logic [LED_NUM_W-1:0] r_led;

  logic                 w_we_ok;
  logic [RGB_W-1:0]     w_ram_rdata;
  logic [RGB_W-1:0]     w_load_rgb;

  assign w_we_ok = host_we && ({1'b0, host_addr} < NUM_EXT);

  ws2812_frame_ram #(
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we_ok),
    .i_waddr (host_addr[IDX_W-1:0]),
    .i_wdata (host_data),
    .i_raddr (r_index[IDX_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

`ifdef WS2812_SEQ_BRIGHTNESS_EN
  // Brightness is picked up per entry, so a mid-frame change hits only later entries.
  assign w_load_rgb = scale_rgb(w_ram_rdata, brightness);
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_load_rgb          = w_ram_rdata;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    write       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (commit) w_state_nxt = LOAD;
      end
      LOAD: begin
        busy        = 1'b1;
        w_state_nxt = STROBE;
      end
      STROBE: begin
        busy        = 1'b1;
        write       = 1'b1;
        w_state_nxt = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (r_gap_cnt <= GAP_ONE) begin
          w_state_nxt = (r_index == LAST_IDX) ? FIN : LOAD;
        end
      end
      FIN: begin
        // busy drops here so the done cycle reads as idle to the host.
        done        = 1'b1;
        w_state_nxt = (r_pending || commit) ? LOAD : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: index, gap counter, pending flag, driver-facing registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index   <= '0;
      r_gap_cnt <= '0;
      r_pending <= 1'b0;
      r_rgb     <= '0;
      r_led     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_index <= '0;
        end
        LOAD: begin
          r_rgb <= w_load_rgb;
          r_led <= LED_NUM_W'(r_index);
        end
        STROBE: begin
          r_gap_cnt <= GAP_INIT;
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_ONE;
          if (w_state_nxt == LOAD) r_index <= r_index + IDX_ONE;
        end
        FIN: begin
          r_index <= '0;
        end
        default: r_index <= '0;
      endcase

      // Any number of commits during a transfer collapse into one re-run.
      if (r_state == FIN) begin
        r_pending <= 1'b0;
      end else if (commit && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign rgb_data = r_rgb;
  assign led_num  = r_led;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: a 4-LED and a 1-LED instance, scoreboarded strobes.
// Expected strobes are queued when a transfer is requested and popped on each write.
// Build with WS2812_SEQ_BRIGHTNESS_EN defined to cover the brightness scaling path.
module tb_ws2812_frame_sequencer;

  localparam int WG = 16;

  typedef struct {
    logic [7:0]  led;
    logic [23:0] rgb;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        host_we   = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [23:0] host_data = '0;
  logic        commit4   = 1'b0;
  logic        commit1   = 1'b0;
  logic [7:0]  brightness = 8'd255;

  logic        busy4, done4, wr4, busy1, done1, wr1;
  logic [23:0] rgb4, rgb1;
  logic [7:0]  led4, led1;

  ws2812_frame_sequencer #(.NUM_LEDS(4), .WRITE_GAP(WG), .ADDR_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .commit(commit4), .brightness(brightness),
    .busy(busy4), .done(done4), .rgb_data(rgb4), .led_num(led4), .write(wr4)
  );

  ws2812_frame_sequencer #(.NUM_LEDS(1), .WRITE_GAP(WG), .ADDR_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .commit(commit1), .brightness(brightness),
    .busy(busy1), .done(done1), .rgb_data(rgb1), .led_num(led1), .write(wr1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference frame contents and expected driver traffic
  logic [23:0] model4 [4];
  logic [23:0] model1;
  exp_t sb4[$];
  exp_t sb1[$];
  int strb4_cyc[$];
  int done4_cyc[$];
  int strb1_cyc[$];
  int done1_cyc[$];
  int last_busy4 = 0;
  exp_t e4, e1;

  function automatic logic [23:0] exp_rgb(input logic [23:0] d);
`ifdef WS2812_SEQ_BRIGHTNESS_EN
    int g, r, b;
    g = (int'(d[23:16]) * int'(brightness)) / 256;
    r = (int'(d[15:8])  * int'(brightness)) / 256;
    b = (int'(d[7:0])   * int'(brightness)) / 256;
    return {8'(g), 8'(r), 8'(b)};
`else
    return d;
`endif
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (busy4) last_busy4 = cyc;
      if (wr4) begin
        strb4_cyc.push_back(cyc);
        check("sb4_nonempty", 32'(sb4.size() != 0), 1);
        if (sb4.size() != 0) begin
          e4 = sb4.pop_front();
          check("led4", led4, e4.led);
          check("rgb4", rgb4, e4.rgb);
        end
      end
      if (done4) begin
        done4_cyc.push_back(cyc);
        check("busy4_at_done", busy4, 0);
      end
      if (wr1) begin
        strb1_cyc.push_back(cyc);
        check("sb1_nonempty", 32'(sb1.size() != 0), 1);
        if (sb1.size() != 0) begin
          e1 = sb1.pop_front();
          check("led1", led1, e1.led);
          check("rgb1", rgb1, e1.rgb);
        end
      end
      if (done1) begin
        done1_cyc.push_back(cyc);
        check("busy1_at_done", busy1, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    if (a < 8'd4) model4[a[1:0]] = d;
    if (a == 8'd0) model1 = d;
    step(1);
    host_we = 1'b0;
  endtask

  task automatic push4();
    for (int k = 0; k < 4; k++) sb4.push_back('{led: 8'(k), rgb: exp_rgb(model4[k])});
  endtask

  task automatic pulse4();
    commit4 = 1'b1;
    step(1);
    commit4 = 1'b0;
  endtask

  task automatic pulse1();
    commit1 = 1'b1;
    step(1);
    commit1 = 1'b0;
  endtask

  task automatic clear_rec();
    strb4_cyc.delete();
    done4_cyc.delete();
    strb1_cyc.delete();
    done1_cyc.delete();
  endtask

  task automatic wait_done(input int which, input int target, input int budget);
    int t = 0;
    while (((which == 4) ? done4_cyc.size() : done1_cyc.size()) < target && t < budget) begin
      step(1);
      t++;
    end
    check((which == 4) ? "done4_within_budget" : "done1_within_budget",
          32'(((which == 4) ? done4_cyc.size() : done1_cyc.size()) >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d1;

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_write", wr4, 0);
    check("rst_rgb", rgb4, 0);
    check("rst_led", led4, 0);
    check("rst_busy1", busy1, 0);
    step(2);
    reset = 1'b0;
    step(1);

    // Load frame; address 9 must be ignored (its low bits alias entry 1)
    wr(8'd0, 24'h110000);
    wr(8'd1, 24'h002200);
    wr(8'd2, 24'h000033);
    wr(8'd3, 24'hFFFFFF);
    host_we = 1'b1; host_addr = 8'd9; host_data = 24'hDEADBE; step(1); host_we = 1'b0;

    // Basic transfer with exact timing
    check("idle_busy", busy4, 0);
    clear_rec();
    c = cyc;
    push4();
    pulse4();
    check("busy_in_load", busy4, 1);
    wait_done(4, 1, 200);
    check("t1_strobe_cnt", strb4_cyc.size(), 4);
    for (int k = 0; k < 4 && k < strb4_cyc.size(); k++)
      check("t1_strobe_cyc", strb4_cyc[k], c + 2 + k * WG);
    if (done4_cyc.size() > 0) check("t1_done_cyc", done4_cyc[0], c + 2 + 3 * WG + WG - 1);
    check("t1_last_busy", last_busy4, c + 2 + 3 * WG + WG - 2);
    step(5);
    check("hold_led", led4, 3);
    check("hold_rgb", rgb4, exp_rgb(24'hFFFFFF));
    check("hold_busy", busy4, 0);

    // Three commits during a transfer collapse into one extra transfer
    clear_rec();
    c = cyc;
    push4();
    pulse4();
    step(9);
    push4();
    pulse4();
    step(9);
    pulse4();
    step(9);
    pulse4();
    wait_done(4, 2, 400);
    if (done4_cyc.size() >= 2) begin
      d1 = done4_cyc[0];
      check("t2_done1_cyc", d1, c + 65);
      check("t2_done2_cyc", done4_cyc[1], d1 + 65);
      if (strb4_cyc.size() > 4) check("t2_restart_cyc", strb4_cyc[4], d1 + 2);
    end
    step(100);
    check("t2_strobe_cnt", strb4_cyc.size(), 8);
    check("t2_done_cnt", done4_cyc.size(), 2);
    check("t2_idle_after", busy4, 0);
    check("t2_sb_drained", sb4.size(), 0);

    // Write-first: entry 2 rewritten in the very cycle it is loaded
    clear_rec();
    model4[2] = 24'h0A0B0C;
    c = cyc;
    push4();
    pulse4();
    step(32);
    wr(8'd2, 24'h0A0B0C);
    wr(8'd9, 24'h123456);
    wait_done(4, 1, 200);
    check("t3_strobe_cnt", strb4_cyc.size(), 4);

    // Asynchronous reset in the gap after index 1, then restart from index 0
    clear_rec();
    c = cyc;
    push4();
    pulse4();
    step(19);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_write", wr4, 0);
    check("arst_done", done4, 0);
    check("arst_rgb", rgb4, 0);
    check("arst_led", led4, 0);
    check("arst_strobes_before", strb4_cyc.size(), 2);
    sb4.delete();
    step(3);
    reset = 1'b0;
    step(2);
    check("post_rst_busy", busy4, 0);
    clear_rec();
    c = cyc;
    push4();
    pulse4();
    wait_done(4, 1, 200);
    check("t4_strobe_cnt", strb4_cyc.size(), 4);
    if (strb4_cyc.size() > 0) check("t4_first_strobe", strb4_cyc[0], c + 2);

    // Single-LED instance
    clear_rec();
    c = cyc;
    sb1.push_back('{led: 8'd0, rgb: exp_rgb(model1)});
    pulse1();
    wait_done(1, 1, 100);
    if (strb1_cyc.size() > 0) check("n1_strobe_cyc", strb1_cyc[0], c + 2);
    if (done1_cyc.size() > 0) check("n1_done_cyc", done1_cyc[0], c + 1 + WG);
    step(40);
    check("n1_strobe_cnt", strb1_cyc.size(), 1);
    check("n1_idle", busy1, 0);

    // Brightness scaling (raw data passes through when the feature is off)
    wr(8'd0, 24'hFF8040);
    brightness = 8'd128;
    clear_rec();
    sb1.push_back('{led: 8'd0, rgb: exp_rgb(model1)});
    pulse1();
    wait_done(1, 1, 100);
`ifdef WS2812_SEQ_BRIGHTNESS_EN
    check("bright128", rgb1, 24'h7F4020);
`else
    check("bright128", rgb1, 24'hFF8040);
`endif
    brightness = 8'd0;
    clear_rec();
    sb1.push_back('{led: 8'd0, rgb: exp_rgb(model1)});
    pulse1();
    wait_done(1, 1, 100);
`ifdef WS2812_SEQ_BRIGHTNESS_EN
    check("bright0", rgb1, 24'h000000);
`else
    check("bright0", rgb1, 24'hFF8040);
`endif
    brightness = 8'd255;
    step(5);
    check("sb1_drained", sb1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
